// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: req/ack data-memory bus between the memory stage and data memory.
interface mem_stage_ctrl_if #(parameter int ADDR_W = 32);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;
    modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_rdata, dmem_ack);
    modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller running req/ack data accesses with lane steering and load extension.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module mem_stage_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memReadEx,
    input  logic              memWriteEx,
    input  logic [1:0]        sizeEx,
    input  logic              signedEx,
    input  logic [ADDR_W-1:0] addrEx,
    input  logic [31:0]       storeDataEx,
    input  logic [4:0]        writeRegEx,
    input  logic              regWriteEx,
    input  logic              memtoregEx,
    mem_stage_ctrl_if.master  dmem,
    output logic [31:0]       read_data,
    output logic [ADDR_W-1:0] data_addr,
    output logic [4:0]        writeRegMem,
    output logic              regWriteMem,
    output logic              memtoregMem,
    output logic              stall,
    output logic              misalign_exc
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d, load_q, load_d, signed_q, signed_d, exc_q, exc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d, read_data_q, read_data_d, load_val;
    logic [1:0]        off_q, off_d, size_q, size_d;
    logic              mem_op, is_byte, is_half, trap;
    logic [3:0]        be_n;
    logic [31:0]       wdata_n;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    assign mem_op  = memReadEx | memWriteEx;
    assign is_byte = sizeEx == 2'b00;
    assign is_half = sizeEx == 2'b01;
    // Low address bits a half/word cannot use are dropped here, so untrapped misaligned ops stay aligned.
    assign be_n    = is_byte ? 4'b0001 << addrEx[1:0] : is_half ? (addrEx[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_n = is_byte ? {4{storeDataEx[7:0]}} : is_half ? {2{storeDataEx[15:0]}} : storeDataEx;
`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (is_half & addrEx[0]) | (~is_byte & ~is_half & (|addrEx[1:0]));
    assign trap       = misaligned;
`else
    assign trap       = 1'b0;
`endif
    assign byte_v   = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
    assign half_v   = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];
    assign load_val = size_q == 2'b00 ? {{24{signed_q & byte_v[7]}}, byte_v}
                    : size_q == 2'b01 ? {{16{signed_q & half_v[15]}}, half_v} : dmem.dmem_rdata;
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        load_d      = load_q;
        signed_d    = signed_q;
        exc_d       = exc_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        read_data_d = read_data_q;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                stall = mem_op;
                if (mem_op && trap) begin
                    state_d = DONE;
                    exc_d   = 1'b1;
                end else if (mem_op) begin
                    state_d  = REQ;
                    req_d    = 1'b1;
                    we_d     = memWriteEx;
                    load_d   = ~memWriteEx;
                    addr_d   = {addrEx[ADDR_W-1:2], 2'b00};
                    be_d     = be_n;
                    wdata_d  = wdata_n;
                    off_d    = addrEx[1:0];
                    size_d   = sizeEx;
                    signed_d = signedEx;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem.dmem_ack) begin
                    state_d     = DONE;
                    req_d       = 1'b0;
                    read_data_d = load_q ? load_val : read_data_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                exc_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            load_q      <= 1'b0;
            signed_q    <= 1'b0;
            exc_q       <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            read_data_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            load_q      <= load_d;
            signed_q    <= signed_d;
            exc_q       <= exc_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            read_data_q <= read_data_d;
        end
    end
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign read_data       = read_data_q;
    assign data_addr       = addrEx;
    assign writeRegMem     = writeRegEx;
    assign memtoregMem     = memtoregEx;
    // A trapped op must not write back, and a stalled cycle becomes a bubble.
    assign regWriteMem     = regWriteEx & ~stall & ~exc_q;
    assign misalign_exc    = exc_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench driving EX/MEM ops and acting as a delayed-ack data memory.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        memReadEx, memWriteEx, signedEx, regWriteEx, memtoregEx;
    logic [1:0]  sizeEx;
    logic [31:0] addrEx, storeDataEx;
    logic [4:0]  writeRegEx;
    logic [31:0] read_data, data_addr;
    logic [4:0]  writeRegMem;
    logic        regWriteMem, memtoregMem, stall, misalign_exc;
    always #5 clk = ~clk;
    mem_stage_ctrl_if #(.ADDR_W(32)) dmem();
    mem_stage_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .memReadEx(memReadEx), .memWriteEx(memWriteEx),
        .sizeEx(sizeEx), .signedEx(signedEx), .addrEx(addrEx), .storeDataEx(storeDataEx),
        .writeRegEx(writeRegEx), .regWriteEx(regWriteEx), .memtoregEx(memtoregEx),
        .dmem(dmem.master), .read_data(read_data), .data_addr(data_addr),
        .writeRegMem(writeRegMem), .regWriteMem(regWriteMem), .memtoregMem(memtoregMem),
        .stall(stall), .misalign_exc(misalign_exc)
    );
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        mis;
    } exp_t;
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rd = 32'h0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask
    function automatic logic [31:0] extract(input logic [1:0] sz, input logic sg, input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'h0, b};
        if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
        return w;
    endfunction
    task automatic clear_ops();
        memReadEx = 0; memWriteEx = 0; regWriteEx = 0; memtoregEx = 0;
        sizeEx = 0; signedEx = 0; addrEx = 0; storeDataEx = 0; writeRegEx = 0;
    endtask
    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                         input int d, input string tag);
        exp_t e;
        logic mis;
        int   stalls = 0;
        int   reqs = 0;
        logic done = 0;
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`ifndef MEM_MISALIGN_TRAP_EN
        mis = 0;
`endif
        e.we    = wr;
        e.addr  = {a[31:2], 2'b00};
        e.be    = sz == 2'b00 ? 4'b0001 << a[1:0] : sz == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        e.wdata = sz == 2'b00 ? {4{sd[7:0]}} : sz == 2'b01 ? {2{sd[15:0]}} : sd;
        if (rd && !wr && !mis) exp_rd = extract(sz, sg, a[1:0], rdata);
        e.rd  = exp_rd;
        e.mis = mis;
        sb.push_back(e);
        @(posedge clk); #1;
        memReadEx = rd; memWriteEx = wr; sizeEx = sz; signedEx = sg; addrEx = a;
        storeDataEx = sd; regWriteEx = rd & ~wr; memtoregEx = rd; writeRegEx = 5'd3;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!stall) done = 1;
            else begin
                stalls++;
                if (dmem.dmem_req) begin
                    reqs++;
                    chk({tag, " addr"}, dmem.dmem_addr, sb[0].addr);
                    chk({tag, " be"}, {28'h0, dmem.dmem_be}, {28'h0, sb[0].be});
                    chk({tag, " wdata"}, dmem.dmem_wdata, sb[0].wdata);
                    chk({tag, " we"}, {31'h0, dmem.dmem_we}, {31'h0, sb[0].we});
                    if (reqs == d + 1) begin
                        dmem.dmem_ack = 1;
                        dmem.dmem_rdata = rdata;
                    end
                end
                @(posedge clk); #1;
                dmem.dmem_ack = 0;
            end
        end
        e = sb.pop_front();
        chk({tag, " done"}, {31'h0, done}, 32'h1);
        chk({tag, " stalls"}, stalls, e.mis ? 1 : 2 + d);
        chk({tag, " reqs"}, reqs, e.mis ? 0 : d + 1);
        chk({tag, " read_data"}, read_data, e.rd);
        chk({tag, " misalign_exc"}, {31'h0, misalign_exc}, {31'h0, e.mis});
        chk({tag, " regWriteMem"}, {31'h0, regWriteMem}, {31'h0, rd & ~wr & ~e.mis});
        chk({tag, " writeRegMem"}, {27'h0, writeRegMem}, 32'd3);
        @(posedge clk); #1;
        clear_ops();
        @(negedge clk);
        chk({tag, " idle stall"}, {31'h0, stall}, 32'h0);
    endtask
    initial begin
        reset = 1;
        clear_ops();
        dmem.dmem_ack = 0;
        dmem.dmem_rdata = 0;
        #12;
        chk("rst req", {31'h0, dmem.dmem_req}, 32'h0);
        chk("rst we", {31'h0, dmem.dmem_we}, 32'h0);
        chk("rst be", {28'h0, dmem.dmem_be}, 32'h0);
        chk("rst addr", dmem.dmem_addr, 32'h0);
        chk("rst wdata", dmem.dmem_wdata, 32'h0);
        chk("rst read_data", read_data, 32'h0);
        chk("rst misalign", {31'h0, misalign_exc}, 32'h0);
        chk("rst stall", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        regWriteEx = 1; writeRegEx = 5'd9; addrEx = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nop stall", {31'h0, stall}, 32'h0);
            chk("nop regWriteMem", {31'h0, regWriteMem}, 32'h1);
            chk("nop writeRegMem", {27'h0, writeRegMem}, 32'd9);
            chk("nop req", {31'h0, dmem.dmem_req}, 32'h0);
            chk("nop data_addr", data_addr, 32'h44);
        end
        clear_ops();
        do_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, "lw");
        do_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 0, "lb");
        do_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 0, "lbu");
        do_op(0, 1, 2'b01, 0, 32'h206, 32'h0000ABCD, 32'h0, 2, "sh");
        do_op(1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h80017FFF, 0, "lh");
        do_op(0, 1, 2'b00, 0, 32'h005, 32'h12345655, 32'h0, 0, "sb");
        do_op(1, 1, 2'b10, 0, 32'h008, 32'hA5A5A5A5, 32'h77777777, 1, "rw");
        do_op(1, 0, 2'b10, 0, 32'h102, 32'h0, 32'hCAFEF00D, 0, "lw_mis");
        do_op(1, 0, 2'b01, 1, 32'h101, 32'h0, 32'h1234F00D, 0, "lh_mis");
        do_op(1, 0, 2'b11, 0, 32'h30C, 32'h0, 32'h0BADF00D, 0, "lsz3");
        @(posedge clk); #1;
        memReadEx = 1; sizeEx = 2'b10; addrEx = 32'h300; regWriteEx = 1;
        for (int c = 0; c < 10 && !dmem.dmem_req; c++) @(negedge clk);
        chk("abort req seen", {31'h0, dmem.dmem_req}, 32'h1);
        reset = 1;
        clear_ops();
        #1;
        exp_rd = 32'h0;
        chk("abort req", {31'h0, dmem.dmem_req}, 32'h0);
        chk("abort stall", {31'h0, stall}, 32'h0);
        chk("abort read_data", read_data, exp_rd);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        dmem.dmem_ack = 1;
        dmem.dmem_rdata = 32'h12345678;
        @(posedge clk); #1;
        dmem.dmem_ack = 0;
        @(negedge clk);
        chk("late ack read_data", read_data, exp_rd);
        chk("late ack req", {31'h0, dmem.dmem_req}, 32'h0);
        chk("late ack stall", {31'h0, stall}, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
